pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_perf_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [31:0] HALT_CODE_DEF = 32'd10;

  // EX wins over MEM; $zero is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] ex_dst,
                                         input logic       ex_we,
                                         input logic [4:0] mem_dst,
                                         input logic       mem_we);
    if (ex_we && ex_dst != 5'd0 && ex_dst == src)
      return FWD_EX;
    else if (mem_we && mem_dst != 5'd0 && mem_dst == src)
      return FWD_MEM;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// Free-running wrap-around event counter with enable and sync reset.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, redirect flush, syscall halt and operand forwarding control
// for a 5-stage pipeline, plus cycle/stall/redirect counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_CODE = HALT_CODE_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_r1_pos,
  input  logic [4:0]       id_r2_pos,
  input  logic             id_use_r1,
  input  logic             id_use_r2,
  input  logic [4:0]       ex_dst,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_dst,
  input  logic             mem_reg_write,
  input  logic             ex_redirect,
  input  logic             ex_syscall,
  input  logic [31:0]      ex_v0,
  input  logic             resume,
  output logic             pc_hold,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_r1,
  output logic [1:0]       fwd_r2,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_cycles,
  output logic [CNT_W-1:0] cnt_stalls,
  output logic [CNT_W-1:0] cnt_redirects
);

  state_e state_q, state_d;
  logic   lu_hazard, halt_req, redir_acc;
  logic   en_cyc, en_stall, en_redir;
  logic [CNT_W-1:0] cyc_q, stall_q, redir_q;

  assign lu_hazard = ex_mem_read && ex_dst != 5'd0 &&
                     ((id_use_r1 && ex_dst == id_r1_pos) ||
                      (id_use_r2 && ex_dst == id_r2_pos));
  assign halt_req  = ex_syscall && ex_v0 == HALT_CODE;

  always_comb begin
    state_d   = state_q;
    pc_hold   = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    halted    = 1'b0;
    redir_acc = 1'b0;
    fwd_r1    = fwd_sel(id_r1_pos, ex_dst, ex_reg_write, mem_dst, mem_reg_write);
    fwd_r2    = fwd_sel(id_r2_pos, ex_dst, ex_reg_write, mem_dst, mem_reg_write);
    if (rst) begin
      state_d = ST_RUN;
      fwd_r1  = FWD_RF;
      fwd_r2  = FWD_RF;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = ST_HALT;
          end else if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            redir_acc = 1'b1;
          end else if (lu_hazard) begin
            pc_hold   = 1'b1;
            bubble_ex = 1'b1;
            state_d   = ST_LU_STALL;
          end
        end
        // EX holds the bubble just inserted; the load is now in MEM.
        ST_LU_STALL: begin
          state_d = ST_RUN;
          if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            redir_acc = 1'b1;
          end
        end
        ST_HALT: begin
          pc_hold   = 1'b1;
          bubble_ex = 1'b1;
          halted    = 1'b1;
          fwd_r1    = FWD_RF;
          fwd_r2    = FWD_RF;
          if (resume) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  assign en_cyc   = state_q != ST_HALT;
  assign en_stall = pc_hold && state_q != ST_HALT;
  assign en_redir = redir_acc;

  perf_counter #(.CNT_W(CNT_W)) u_cnt_cyc (
    .clk(clk), .rst(rst), .en_i(en_cyc), .cnt_o(cyc_q)
  );
  perf_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk(clk), .rst(rst), .en_i(en_stall), .cnt_o(stall_q)
  );
  perf_counter #(.CNT_W(CNT_W)) u_cnt_redir (
    .clk(clk), .rst(rst), .en_i(en_redir), .cnt_o(redir_q)
  );

  // Counters read as zero while reset is held, like every other output.
  assign cnt_cycles    = rst ? '0 : cyc_q;
  assign cnt_stalls    = rst ? '0 : stall_q;
  assign cnt_redirects = rst ? '0 : redir_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; narrow counters so wrap is reachable.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_r1_pos, id_r2_pos, ex_dst, mem_dst;
  logic             id_use_r1, id_use_r2, ex_reg_write, ex_mem_read;
  logic             mem_reg_write, ex_redirect, ex_syscall, resume;
  logic [31:0]      ex_v0;
  logic             pc_hold, bubble_ex, flush_id, halted;
  logic [1:0]       fwd_r1, fwd_r2;
  logic [CNT_W-1:0] cnt_cycles, cnt_stalls, cnt_redirects;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.HALT_CODE(32'd10), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_r1_pos(id_r1_pos), .id_r2_pos(id_r2_pos),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_reg_write(mem_reg_write),
    .ex_redirect(ex_redirect), .ex_syscall(ex_syscall), .ex_v0(ex_v0),
    .resume(resume),
    .pc_hold(pc_hold), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_r1(fwd_r1), .fwd_r2(fwd_r2), .halted(halted),
    .cnt_cycles(cnt_cycles), .cnt_stalls(cnt_stalls), .cnt_redirects(cnt_redirects)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_r1_pos = 0; id_r2_pos = 0; id_use_r1 = 0; id_use_r2 = 0;
    ex_dst = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_dst = 0; mem_reg_write = 0;
    ex_redirect = 0; ex_syscall = 0; ex_v0 = 0; resume = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Reset overrides live hazard inputs
    ex_syscall = 1; ex_v0 = 10; ex_redirect = 1;
    ex_mem_read = 1; ex_dst = 5; id_r1_pos = 5; id_use_r1 = 1;
    @(negedge clk); #1;
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_bubble", bubble_ex, 0);
    chk("rst_flush", flush_id, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fwd_r1", fwd_r1, 0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_cyc", cnt_cycles, 0);
    chk("post_rst_stall", cnt_stalls, 0);
    chk("post_rst_fwd", fwd_r1, 0);
    tick();                                            // cyc=1

    // lw $5 in EX, add reads $5 in ID
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5; id_r1_pos = 5; id_use_r1 = 1;
    #1;
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_bubble", bubble_ex, 1);
    chk("lu_flush", flush_id, 0);
    tick();                                            // LU_STALL, cyc=2, stalls=1
    ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0;
    mem_dst = 5; mem_reg_write = 1;
    #1;
    chk("lus_pc_hold", pc_hold, 0);
    chk("lus_bubble", bubble_ex, 0);
    chk("lus_fwd_r1", fwd_r1, 2);
    chk("lus_stalls", cnt_stalls, 1);
    tick();                                            // RUN, cyc=3
    #1;
    chk("run_pc_hold", pc_hold, 0);
    chk("run_stalls", cnt_stalls, 1);
    chk("run_cyc", cnt_cycles, 3);
    tick();                                            // cyc=4

    // Load-use and redirect together: redirect wins
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5; id_r1_pos = 5; id_use_r1 = 1;
    ex_redirect = 1;
    #1;
    chk("lur_flush", flush_id, 1);
    chk("lur_bubble", bubble_ex, 1);
    chk("lur_pc_hold", pc_hold, 0);
    tick();                                            // cyc=5, redirects=1
    idle();
    #1;
    chk("lur_redirects", cnt_redirects, 1);
    chk("lur_stalls", cnt_stalls, 1);
    chk("lur_stay_run", pc_hold, 0);
    chk("lur_bubble_off", bubble_ex, 0);
    tick();                                            // cyc=6

    // Forwarding priority and $zero
    ex_dst = 7; ex_reg_write = 1; mem_dst = 7; mem_reg_write = 1;
    id_r1_pos = 7; id_r2_pos = 7; id_use_r1 = 1; id_use_r2 = 1;
    #1;
    chk("fwd_ex_pri_r1", fwd_r1, 1);
    chk("fwd_ex_pri_r2", fwd_r2, 1);
    mem_dst = 9; id_r2_pos = 9;
    #1;
    chk("fwd_mem_r2", fwd_r2, 2);
    chk("fwd_ex_r1", fwd_r1, 1);
    ex_dst = 0; mem_dst = 0; id_r1_pos = 0; id_r2_pos = 0;
    #1;
    chk("fwd_zero_r1", fwd_r1, 0);
    chk("fwd_zero_r2", fwd_r2, 0);
    tick();                                            // cyc=7

    // Non-halting syscall
    idle();
    ex_syscall = 1; ex_v0 = 1;
    #1;
    chk("sys1_flush", flush_id, 0);
    chk("sys1_bubble", bubble_ex, 0);
    tick();                                            // cyc=8
    idle();
    #1;
    chk("sys1_halted", halted, 0);

    // Halting syscall beats redirect and load-use
    ex_syscall = 1; ex_v0 = 10; ex_redirect = 1;
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5; id_r1_pos = 5; id_use_r1 = 1;
    #1;
    chk("sys10_flush", flush_id, 1);
    chk("sys10_bubble", bubble_ex, 1);
    chk("sys10_pc_hold", pc_hold, 0);
    tick();                                            // HALT, cyc=9
    idle();
    ex_dst = 7; ex_reg_write = 1; id_r1_pos = 7; id_use_r1 = 1;
    #1;
    chk("halt_halted", halted, 1);
    chk("halt_pc_hold", pc_hold, 1);
    chk("halt_bubble", bubble_ex, 1);
    chk("halt_fwd_r1", fwd_r1, 0);
    chk("halt_cyc", cnt_cycles, 9);
    chk("halt_redirects", cnt_redirects, 1);
    tick();
    #1;
    chk("halt_cyc_frozen", cnt_cycles, 9);
    chk("halt_stalls_frozen", cnt_stalls, 1);
    resume = 1;
    tick();                                            // RUN, cyc still 9
    resume = 0;
    #1;
    chk("resume_halted", halted, 0);
    chk("resume_cyc", cnt_cycles, 9);
    tick();                                            // cyc=10
    resume = 1;
    tick();                                            // cyc=11
    resume = 0;
    #1;
    chk("resume_ignored", halted, 0);
    chk("resume_cyc2", cnt_cycles, 11);

    // Reset while halted
    idle();
    ex_syscall = 1; ex_v0 = 10;
    tick();                                            // HALT
    idle();
    #1;
    chk("halt2_halted", halted, 1);
    rst = 1;
    #1;
    chk("rsth_halted", halted, 0);
    chk("rsth_pc_hold", pc_hold, 0);
    chk("rsth_bubble", bubble_ex, 0);
    chk("rsth_cyc", cnt_cycles, 0);
    tick();
    rst = 0;
    #1;
    chk("rsth_rel_halted", halted, 0);
    chk("rsth_rel_pc_hold", pc_hold, 0);
    chk("rsth_rel_cyc", cnt_cycles, 0);

    // Reset while in LU_STALL
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5; id_r1_pos = 5; id_use_r1 = 1;
    tick();                                            // LU_STALL
    rst = 1;
    tick();
    rst = 0;
    idle();
    #1;
    chk("rstl_pc_hold", pc_hold, 0);
    chk("rstl_bubble", bubble_ex, 0);
    chk("rstl_stalls", cnt_stalls, 0);
    chk("rstl_cyc", cnt_cycles, 0);

    // Cycle counter wraps at 2^CNT_W
    for (int i = 0; i < 15; i++) tick();
    #1;
    chk("cyc_max", cnt_cycles, 15);
    tick();
    #1;
    chk("cyc_wrap", cnt_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
